ask2_current_limit_ctrl: RTL

- Over-current protection sequencer for the ASK2 controller.
- Compares each ADC current sample against the 16-bit I_max limit that the Nios CPU writes through its PIO output port.
- Debounces violations, trips and latches a fault, gates the power-stage enable and raises an interrupt.
- Enforces a programmable cooldown after the CPU clears the fault; it also exposes a small Avalon-MM slave for status, configuration and peak capture.

---
 rtl/ask2_current_limit_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ask2_current_limit_ctrl.sv
// ASK2 over-current protection sequencer: debounced trip, latched fault, cooldown
// after CPU clear, and an Avalon-MM slave for status, configuration and peak capture.
module ask2_current_limit_ctrl #(
  parameter logic [7:0]  DEBOUNCE_DEFAULT = 8'd4,
  parameter logic [15:0] COOLDOWN_DEFAULT = 16'd1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] i_max,
  input  logic        adc_valid,
  input  logic [15:0] adc_data,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        pwm_enable,
  output logic        fault,
  output logic        irq
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_PENDING  = 2'd1;
  localparam logic [1:0] ST_TRIPPED  = 2'd2;
  localparam logic [1:0] ST_COOLDOWN = 2'd3;

  logic [1:0]  state, state_nx;
  logic [7:0]  over_cnt, over_cnt_nx;
  logic [15:0] cd_cnt, cd_cnt_nx;
  logic [7:0]  deb;
  logic [15:0] cool;
  logic [15:0] peak;

  logic        wr;
  logic        over;
  logic        clear_req;
  logic [7:0]  deb_eff;
  logic [8:0]  cnt_inc;
  logic        unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign over         = adc_valid & (i_max != 16'd0) & (adc_data > i_max);
  assign clear_req    = wr & (address == 2'd0) & writedata[0];
  assign deb_eff      = (deb == 8'd0) ? 8'd1 : deb;
  assign cnt_inc      = {1'b0, over_cnt} + 9'd1;
  assign unused_wdata = ^writedata[31:16];
  assign irq          = fault;

  // >= rather than == so a debounce lowered mid-pending still trips instead of wrapping
  always_comb begin
    state_nx    = state;
    over_cnt_nx = over_cnt;
    cd_cnt_nx   = cd_cnt;
    case (state)
      ST_RUN: begin
        if (over) begin
          if (deb_eff == 8'd1) begin
            state_nx = ST_TRIPPED;
          end else begin
            state_nx    = ST_PENDING;
            over_cnt_nx = 8'd1;
          end
        end
      end
      ST_PENDING: begin
        if (over) begin
          if (cnt_inc >= {1'b0, deb_eff}) begin
            state_nx    = ST_TRIPPED;
            over_cnt_nx = 8'd0;
          end else begin
            over_cnt_nx = cnt_inc[7:0];
          end
        end else if (adc_valid) begin
          state_nx    = ST_RUN;
          over_cnt_nx = 8'd0;
        end
      end
      ST_TRIPPED: begin
        if (clear_req) begin
          state_nx  = ST_COOLDOWN;
          cd_cnt_nx = cool;
        end
      end
      ST_COOLDOWN: begin
        if (cd_cnt == 16'd0) begin
          state_nx    = ST_RUN;
          over_cnt_nx = 8'd0;
        end else begin
          cd_cnt_nx = cd_cnt - 16'd1;
        end
      end
      default: begin
        state_nx    = ST_RUN;
        over_cnt_nx = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      over_cnt   <= 8'd0;
      cd_cnt     <= 16'd0;
      pwm_enable <= 1'b1;
      fault      <= 1'b0;
    end else begin
      state      <= state_nx;
      over_cnt   <= over_cnt_nx;
      cd_cnt     <= cd_cnt_nx;
      pwm_enable <= (state_nx == ST_RUN) || (state_nx == ST_PENDING);
      fault      <= (state_nx == ST_TRIPPED);
    end
  end

  // A peak-clear coinciding with a sample restarts the capture from that sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb  <= DEBOUNCE_DEFAULT;
      cool <= COOLDOWN_DEFAULT;
      peak <= 16'd0;
    end else begin
      if (wr && address == 2'd1) deb  <= writedata[7:0];
      if (wr && address == 2'd3) cool <= writedata[15:0];
      if (wr && address == 2'd2) begin
        peak <= adc_valid ? adc_data : 16'd0;
      end else if (adc_valid && adc_data > peak) begin
        peak <= adc_data;
      end
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0: readdata = {28'd0, state, pwm_enable, fault};
      2'd1: readdata = {24'd0, deb};
      2'd2: readdata = {16'd0, peak};
      2'd3: readdata = {16'd0, cool};
      default: readdata = 32'd0;
    endcase
  end

endmodule
